snapshot_uploader: RTL

- Read-direction counterpart of the snapshot loader path.
- Sequences a RAM region out to the host over the ioctl byte interface for "Save snapshot".
- Pauses the CPU, fetches bytes through a single-outstanding memory read handshake, and presents each byte to the host with wait/strobe flow control.
- Keeps a running XOR checksum of the bytes transferred.

---
 rtl/snapshot_uploader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/snapshot_uploader.sv
// Streams a RAM region to the host over the ioctl byte interface while the CPU is halted,
// one memory read outstanding at a time, with a running XOR checksum of consumed bytes.
module snapshot_uploader #(
   parameter logic [15:0] BASE_ADDR    = 16'h2000,
   parameter int          LENGTH       = 32'h0000_E000,
   parameter int          HALT_TIMEOUT = 1024
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic        ioctl_rd,
   output logic [7:0]  ioctl_din,
   output logic        ioctl_wait,
   output logic [15:0] ioctl_addr,
   output logic        cpu_halt_req,
   input  logic        cpu_halt_ack,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic        mem_ack,
   input  logic [7:0]  mem_din,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  checksum
);

   localparam int          TW          = $clog2(HALT_TIMEOUT + 1);
   localparam logic [15:0] LAST_OFFSET = 16'(LENGTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      FETCH,
      READY,
      RELEASE
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   offset_q, offset_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    din_q, din_d;
   logic [7:0]    checksum_q, checksum_d;
   logic [15:0]   mem_addr_q, mem_addr_d;
   logic          mem_rd_q, mem_rd_d;
   logic          wait_q, wait_d;
   logic          halt_req_q, halt_req_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;

   always_comb begin
      state_d    = state_q;
      offset_d   = offset_q;
      timer_d    = timer_q;
      din_d      = din_q;
      checksum_d = checksum_q;
      error_d    = error_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d    = HALT;
               offset_d   = '0;
               checksum_d = '0;
               error_d    = 1'b0;
               timer_d    = TW'(HALT_TIMEOUT);
            end
         end
         HALT: begin
            if (abort) begin
               state_d = RELEASE;
            end else if (cpu_halt_ack) begin
               state_d = FETCH;
            end else if (timer_q <= TW'(1)) begin
               error_d = 1'b1;
               state_d = RELEASE;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         FETCH: begin
            if (abort) begin
               state_d = RELEASE;
            end else if (mem_rd_q && mem_ack) begin
               din_d   = mem_din;
               state_d = READY;
            end
         end
         READY: begin
            if (abort) begin
               state_d = RELEASE;
            end else if (ioctl_rd) begin
               checksum_d = checksum_q ^ din_q;
               if (offset_q == LAST_OFFSET) begin
                  state_d = RELEASE;
                  done_d  = 1'b1;
               end else begin
                  offset_d = offset_q + 16'd1;
                  state_d  = FETCH;
               end
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A request, once raised, is held until acked; a new one waits for the CPU to be halted.
      mem_rd_d   = (state_d == FETCH) && (mem_rd_q || cpu_halt_ack);
      mem_addr_d = (state_d == FETCH) ? (BASE_ADDR + offset_d) : mem_addr_q;
      wait_d     = (state_d != READY);
      halt_req_d = (state_d == HALT) || (state_d == FETCH) || (state_d == READY);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         offset_q   <= '0;
         timer_q    <= '0;
         din_q      <= '0;
         checksum_q <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         wait_q     <= 1'b1;
         halt_req_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         offset_q   <= offset_d;
         timer_q    <= timer_d;
         din_q      <= din_d;
         checksum_q <= checksum_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         wait_q     <= wait_d;
         halt_req_q <= halt_req_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign ioctl_din    = din_q;
   assign ioctl_wait   = wait_q;
   assign ioctl_addr   = offset_q;
   assign cpu_halt_req = halt_req_q;
   assign mem_addr     = mem_addr_q;
   assign mem_rd       = mem_rd_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign checksum     = checksum_q;

endmodule
